lc3_mem_ctrl: RTL

//  Parametrised memory-access controller between the LC3 datapath and RAM.

---
 rtl/lc3_mem_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_ctrl
// Description : LC3 memory-access controller owning MAR/MDR, with wait states,
//               a mem_ready handshake and an optional ready timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_rdy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int c_WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int c_TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(WAIT_STATES);
  localparam logic [c_TO_W-1:0]   c_TO_MAX   = c_TO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_mdr;
  logic                r_we;
  logic                r_err;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic                w_wait_hit;
  logic                w_to_hit;

  assign w_wait_hit = (r_wait_cnt == c_WAIT_MAX);

  // With TIMEOUT=0 the controller waits for mem_ready indefinitely.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign w_to_hit = (r_to_cnt == c_TO_MAX);
    end else begin : g_no_timeout
      assign w_to_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_rdy     = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_rdy = 1'b1;
        if (req) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_en = 1'b1;
        mem_we = r_we;
        if (w_wait_hit && (mem_ready || w_to_hit)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // MAR/MDR/we are only loaded on acceptance and on the ready cycle, so they
  // stay stable for the whole access whatever the requester does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mar      <= '0;
      r_mdr      <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_mar      <= req_addr;
            r_we       <= req_we;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
            r_to_cnt   <= '0;
            if (req_we) begin
              r_mdr <= req_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (!w_wait_hit) begin
            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
          end else if (mem_ready) begin
            r_err <= 1'b0;
            if (!r_we) begin
              r_mdr <= mem_rdata;
            end
          end else if (w_to_hit) begin
            r_err <= 1'b1;
          end else if (r_to_cnt != c_TO_MAX) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rdata     = r_mdr;
  assign mem_addr  = r_mar;
  assign mem_wdata = r_mdr;

endmodule
`default_nettype wire
